// File: rtl/sfu_pkg.sv
// Shared widths, output mode encoding and signed clamp helper for the SFU accumulator bank.
package sfu_pkg;

  localparam int PSUM_BW_D = 16;
  localparam int ACC_BW_D  = 20;
  localparam int OUT_BW_D  = 16;
  localparam int NUM_CH_D  = 16;

  localparam logic MODE_PASS = 1'b0;
  localparam logic MODE_RELU = 1'b1;

  function automatic logic signed [63:0] clamp_s(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sfu_clamp.sv
// Output path: optional ReLU, then signed saturation from in_bw down to out_bw.
module sfu_clamp
  import sfu_pkg::*;
#(
  parameter int in_bw  = ACC_BW_D,
  parameter int out_bw = OUT_BW_D
) (
  input  logic signed [in_bw-1:0]  din,
  input  logic                     relu_en,
  output logic signed [out_bw-1:0] dout
);

  logic signed [63:0] ext;

  always_comb begin
    ext = 64'(din);
    if (relu_en == MODE_RELU && ext[63]) ext = '0;
    dout = out_bw'(clamp_s(ext, out_bw));
  end

endmodule

// File: rtl/sfu_acc_bank.sv
// Per-channel signed accumulator bank with registered clamp/ReLU drain.
// Define SFU_ACC_SATURATE_EN for saturating accumulation with sticky ovf.
module sfu_acc_bank
  import sfu_pkg::*;
#(
  parameter int psum_bw = PSUM_BW_D,
  parameter int acc_bw  = ACC_BW_D,
  parameter int out_bw  = OUT_BW_D,
  parameter int num_ch  = NUM_CH_D,
  parameter int ptr_bw  = $clog2(num_ch)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [psum_bw-1:0] psum_in,
  input  logic                      valid,
  input  logic                      enable,
  input  logic                      out_en,
  input  logic                      relu_en,
  input  logic                      clr_on_rd,
  input  logic                      clr,
  output logic [out_bw-1:0]         psum_out,
  output logic                      out_valid,
  output logic [ptr_bw-1:0]         in_ptr_o,
  output logic                      ovf
);

  localparam logic [ptr_bw-1:0] LAST = ptr_bw'(num_ch - 1);

  logic signed [acc_bw-1:0] bank [num_ch];
  logic [ptr_bw-1:0]        in_ptr;
  logic [ptr_bw-1:0]        out_ptr;
  logic                     acc_go;
  logic                     same;
  logic signed [acc_bw-1:0] base;
  logic signed [acc_bw-1:0] nxt;
  logic signed [acc_bw-1:0] rd_val;
  logic signed [out_bw-1:0] clamp_out;

  assign in_ptr_o = in_ptr;

  // A clear-on-read of the entry being accumulated restarts it from zero.
  always_comb begin
    acc_go = valid & enable;
    same   = out_en & clr_on_rd & (in_ptr == out_ptr);
    base   = same ? '0 : bank[in_ptr];
    rd_val = bank[out_ptr];
  end

`ifdef SFU_ACC_SATURATE_EN
  logic signed [acc_bw:0] sum;
  logic                   sat_hit;

  always_comb begin
    sum     = (acc_bw+1)'(base) + (acc_bw+1)'(psum_in);
    nxt     = acc_bw'(clamp_s(64'(sum), acc_bw));
    sat_hit = sum[acc_bw] ^ sum[acc_bw-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 ovf <= 1'b0;
    else if (clr)              ovf <= 1'b0;
    else if (acc_go && sat_hit) ovf <= 1'b1;
  end
`else
  always_comb begin
    nxt = base + acc_bw'(psum_in);
  end

  assign ovf = 1'b0;
`endif

  sfu_clamp #(
    .in_bw  (acc_bw),
    .out_bw (out_bw)
  ) u_clamp (
    .din     (rd_val),
    .relu_en (relu_en),
    .dout    (clamp_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < num_ch; i++) bank[i] <= '0;
      in_ptr    <= '0;
      out_ptr   <= '0;
      psum_out  <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < num_ch; i++) bank[i] <= '0;
      in_ptr    <= '0;
      out_ptr   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_en;
      if (out_en) begin
        psum_out <= clamp_out;
        out_ptr  <= (out_ptr == LAST) ? '0 : out_ptr + 1'b1;
        if (clr_on_rd) bank[out_ptr] <= '0;
      end
      if (acc_go) begin
        bank[in_ptr] <= nxt;
        in_ptr       <= (in_ptr == LAST) ? '0 : in_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sfu_acc_bank.sv
// Directed vector bench for sfu_acc_bank: default instance plus a 4-channel, 16-bit-acc instance.
module tb_sfu_acc_bank;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic signed [15:0] psum_in;
  logic valid, enable, out_en, relu_en, clr_on_rd, clr;
  logic [15:0] psum_out;
  logic out_valid;
  logic [3:0] in_ptr_o;
  logic ovf;

  logic signed [15:0] s_psum;
  logic s_valid, s_rd, s_clr;
  logic [15:0] s_out;
  logic s_ovalid;
  logic [1:0] s_ptr;
  logic s_ovf;

  sfu_acc_bank u_dut (
    .clk(clk), .reset(reset), .psum_in(psum_in), .valid(valid),
    .enable(enable), .out_en(out_en), .relu_en(relu_en),
    .clr_on_rd(clr_on_rd), .clr(clr), .psum_out(psum_out),
    .out_valid(out_valid), .in_ptr_o(in_ptr_o), .ovf(ovf)
  );

  sfu_acc_bank #(
    .psum_bw(16), .acc_bw(16), .out_bw(16), .num_ch(4)
  ) u_small (
    .clk(clk), .reset(reset), .psum_in(s_psum), .valid(s_valid),
    .enable(1'b1), .out_en(s_rd), .relu_en(1'b0),
    .clr_on_rd(1'b1), .clr(s_clr), .psum_out(s_out),
    .out_valid(s_ovalid), .in_ptr_o(s_ptr), .ovf(s_ovf)
  );

  typedef struct {
    logic signed [15:0] p;
    logic v, en, rd, relu, cor, cl, ev;
    logic [15:0] eo;
  } vec_t;

  vec_t tv[$];
  logic [15:0] last;
  int checks = 0;
  int passed = 0;

`ifdef SFU_ACC_SATURATE_EN
  localparam logic        EXP_OVF = 1'b1;
  localparam logic [15:0] EXP_SAT = 16'h7FFF;
`else
  localparam logic        EXP_OVF = 1'b0;
  localparam logic [15:0] EXP_SAT = 16'hFFFE;
`endif

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", n, got, exp);
  endtask

  function automatic void add(input logic signed [15:0] p,
                              input logic v, en, rd, relu, cor, cl, ev,
                              input logic [15:0] eo);
    vec_t t;
    if (ev) last = eo;
    t.p = p; t.v = v; t.en = en; t.rd = rd; t.relu = relu;
    t.cor = cor; t.cl = cl; t.ev = ev; t.eo = last;
    tv.push_back(t);
  endfunction

  function automatic void wr(input logic signed [15:0] p);
    add(p, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endfunction

  function automatic void rdv(input logic relu, input logic cor, input logic [15:0] eo);
    add(16'sd0, 1'b0, 1'b0, 1'b1, relu, cor, 1'b0, 1'b1, eo);
  endfunction

  function automatic void do_clr();
    add(16'sd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
  endfunction

  task automatic run(input string tag);
    foreach (tv[i]) begin
      psum_in = tv[i].p; valid = tv[i].v; enable = tv[i].en;
      out_en = tv[i].rd; relu_en = tv[i].relu;
      clr_on_rd = tv[i].cor; clr = tv[i].cl;
      @(posedge clk); #1;
      chk($sformatf("%s[%0d] out_valid", tag, i), 32'(out_valid), 32'(tv[i].ev));
      chk($sformatf("%s[%0d] psum_out", tag, i), 32'(psum_out), 32'(tv[i].eo));
    end
    psum_in = '0; valid = 0; enable = 0; out_en = 0;
    relu_en = 0; clr_on_rd = 0; clr = 0;
    tv.delete();
  endtask

  task automatic sstep(input logic signed [15:0] p, input logic v, rd, cl);
    s_psum = p; s_valid = v; s_rd = rd; s_clr = cl;
    @(posedge clk); #1;
    s_psum = '0; s_valid = 0; s_rd = 0; s_clr = 0;
  endtask

  initial begin
    psum_in = '0; valid = 0; enable = 0; out_en = 0;
    relu_en = 0; clr_on_rd = 0; clr = 0;
    s_psum = '0; s_valid = 0; s_rd = 0; s_clr = 0;
    #12;
    chk("reset psum_out", 32'(psum_out), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ptr", 32'(in_ptr_o), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    @(negedge clk) reset = 0;
    last = '0;

    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++) wr(16'(c + 1));
    for (int c = 0; c < 16; c++) rdv(1'b1, 1'b1, 16'(2 * (c + 1)));
    add(16'sd0, 0, 0, 0, 0, 0, 0, 0, 16'd0);
    run("t1");
    chk("t1 in_ptr wrap", 32'(in_ptr_o), 32'd0);

    add(16'sd99, 1'b1, 1'b0, 0, 0, 0, 0, 0, 16'd0);
    wr(-16'sd5);
    wr(-16'sd5);
    rdv(1'b1, 1'b1, 16'd0);
    rdv(1'b0, 1'b1, 16'hFFFB);
    run("t2");
    chk("t2 in_ptr", 32'(in_ptr_o), 32'd2);

    do_clr();
    for (int k = 0; k < 64; k++) wr(16'sh7FFF);
    rdv(1'b0, 1'b1, 16'h7FFF);
    rdv(1'b1, 1'b1, 16'h7FFF);
    run("t3");
    chk("t3 ovf", 32'(ovf), 32'd0);

    do_clr();
    for (int k = 0; k < 3; k++) rdv(1'b0, 1'b1, 16'd0);
    for (int k = 0; k < 3; k++) wr(16'sd0);
    wr(16'sd10);
    for (int k = 0; k < 15; k++) wr(16'sd0);
    add(16'sd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd10);
    for (int k = 0; k < 15; k++) rdv(1'b0, 1'b1, 16'd0);
    rdv(1'b0, 1'b1, 16'd7);
    run("t4");

    wr(16'sd3);
    rdv(1'b0, 1'b0, 16'd3);
    run("t6a");
    #2 reset = 1;
    #1;
    chk("t6 rst out_valid", 32'(out_valid), 32'd0);
    chk("t6 rst psum_out", 32'(psum_out), 32'd0);
    chk("t6 rst in_ptr", 32'(in_ptr_o), 32'd0);
    chk("t6 rst ovf", 32'(ovf), 32'd0);
    @(negedge clk) reset = 0;
    last = '0;
    for (int k = 0; k < 5; k++) rdv(1'b0, 1'b0, 16'd0);
    wr(16'sd9);
    rdv(1'b0, 1'b0, 16'd0);
    add(16'sd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    rdv(1'b0, 1'b0, 16'd0);
    run("t6b");
    chk("t6 clr in_ptr", 32'(in_ptr_o), 32'd0);
    chk("t6 clr ovf", 32'(ovf), 32'd0);

    for (int k = 1; k <= 5; k++) begin
      sstep(16'(k), 1'b1, 1'b0, 1'b0);
      if (k == 4) chk("t5 ptr after 4", 32'(s_ptr), 32'd0);
      if (k == 5) chk("t5 ptr after 5", 32'(s_ptr), 32'd1);
    end
    sstep(16'sd0, 1'b0, 1'b1, 1'b0);
    chk("t5 ch0 valid", 32'(s_ovalid), 32'd1);
    chk("t5 ch0 sum", 32'(s_out), 32'd6);

    sstep(16'sd0, 1'b0, 1'b0, 1'b1);
    chk("t3b clr ptr", 32'(s_ptr), 32'd0);
    sstep(16'sh7FFF, 1'b1, 1'b0, 1'b0);
    chk("t3b ovf first add", 32'(s_ovf), 32'd0);
    for (int k = 0; k < 3; k++) sstep(16'sd0, 1'b1, 1'b0, 1'b0);
    sstep(16'sh7FFF, 1'b1, 1'b0, 1'b0);
    chk("t3b ovf second add", 32'(s_ovf), 32'(EXP_OVF));
    sstep(16'sd0, 1'b0, 1'b1, 1'b0);
    chk("t3b ch0 value", 32'(s_out), 32'(EXP_SAT));
    sstep(16'sd0, 1'b0, 1'b0, 1'b1);
    chk("t3b ovf after clr", 32'(s_ovf), 32'd0);
    chk("t3b valid after clr", 32'(s_ovalid), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
